// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder slice.
// Contents:
//   - default MMIO window base and the register offsets inside it
//   - STATUS register bit positions
//   - merge_lanes(): byte-lane merge of a store into an existing word
package data_bus_responder_pkg;

  localparam logic [7:0] MMIO_BASE_DEFAULT = 8'hF0;

  // Word offset inside the 16-byte MMIO window (access_address[3:2]).
  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_GPIO    = 2'd3
  } mmio_reg_e;

  localparam int STATUS_MATCH  = 0;
  localparam int STATUS_IRQ_EN = 1;

  // Lane i of the result comes from new_word when be[i] is set, else old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Processor data-access bus.
//   access_address : byte address (bits [1:0] ignored by the responder)
//   data_write     : store data
//   byte_enable    : per-lane store qualifier
//   write_enable   : store strobe for the current cycle
//   data_read      : load data, one cycle after the address
// Modports: master = processor side, slave = responder side.
interface data_bus_responder_if;
  logic [7:0]  access_address;
  logic [31:0] data_write;
  logic [3:0]  byte_enable;
  logic        write_enable;
  logic [31:0] data_read;

  modport master (
    output access_address, data_write, byte_enable, write_enable,
    input  data_read
  );

  modport slave (
    input  access_address, data_write, byte_enable, write_enable,
    output data_read
  );
endinterface

// File: rtl/data_bus_responder_mmio_timer.sv
// Free-running cycle counter plus compare/interrupt timer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   wr_en      : store into the MMIO window this cycle
//   offset     : register selected inside the window (used for read and write)
//   wdata, be  : store data and byte enables
//   rdata      : combinational read value of COUNT/COMPARE/STATUS (0 for GPIO)
//   timer_irq  : match & irq_en
module mmio_timer
  import data_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  mmio_reg_e   offset,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  logic [31:0] count_reg, count_next;
  logic [31:0] compare_reg, compare_next;
  logic        match_reg, match_next;
  logic        irq_en_reg, irq_en_next;
  logic        compare_wr, status_wr, match_set, match_clr;

  always_comb begin
    compare_wr   = wr_en && (offset == REG_COMPARE);
    // STATUS only has bits in lane 0, so a store without lane 0 does nothing.
    status_wr    = wr_en && (offset == REG_STATUS) && be[0];
    match_set    = (count_reg == compare_reg);
    match_clr    = status_wr && wdata[STATUS_MATCH];
    count_next   = count_reg + 32'd1;
    compare_next = compare_wr ? merge_lanes(compare_reg, wdata, be) : compare_reg;
    // A new match on the same cycle as a clear keeps the flag set.
    match_next   = match_set | (match_reg & ~match_clr);
    irq_en_next  = status_wr ? wdata[STATUS_IRQ_EN] : irq_en_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      compare_reg <= 32'hFFFF_FFFF;
      match_reg   <= 1'b0;
      irq_en_reg  <= 1'b0;
    end else begin
      count_reg   <= count_next;
      compare_reg <= compare_next;
      match_reg   <= match_next;
      irq_en_reg  <= irq_en_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_COUNT:   rdata = count_reg;
      REG_COMPARE: rdata = compare_reg;
      REG_STATUS: begin
        rdata[STATUS_MATCH]  = match_reg;
        rdata[STATUS_IRQ_EN] = irq_en_reg;
      end
      default:     rdata = '0;
    endcase
  end

  assign timer_irq = match_reg & irq_en_reg;

endmodule

// File: rtl/data_bus_responder.sv
// Responder end of the processor data bus: byte-enabled word RAM at the
// bottom of the 8-bit address space and a 4-word MMIO window (COUNT,
// COMPARE, STATUS, GPIO) at MMIO_BASE. Every cycle is a read with one
// cycle of registered latency; stores land on the clock edge.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : data bus, slave side
//   gpio_out   : GPIO register
//   timer_irq  : timer interrupt level
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int         RAM_WORDS = 60,
  parameter logic [7:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  data_bus_responder_if.slave   bus,
  output logic [31:0]           gpio_out,
  output logic                  timer_irq
);

  localparam int         RAM_AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [6:0] RAM_WORDS_L = 7'(RAM_WORDS);

  logic [5:0]        word_index;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_hit, mmio_hit, ram_we, mmio_we, gpio_wr;
  logic [3:0]        lane_we;
  mmio_reg_e         mmio_offset;
  logic [31:0]       timer_rdata;
  logic [31:0]       gpio_reg, gpio_next;
  logic [31:0]       data_read_reg;
  logic [31:0]       ram_mem [RAM_WORDS];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.access_address[1:0];

  assign word_index  = bus.access_address[7:2];
  assign ram_addr    = word_index[RAM_AW-1:0];
  assign ram_hit     = ({1'b0, word_index} < RAM_WORDS_L);
  assign mmio_hit    = (bus.access_address[7:4] == MMIO_BASE[7:4]);
  assign mmio_offset = mmio_reg_e'(bus.access_address[3:2]);

  // RAM stores are blocked while reset is high so RAM state is deterministic.
  assign ram_we  = bus.write_enable && ram_hit && !reset;
  assign mmio_we = bus.write_enable && mmio_hit;
  assign gpio_wr = mmio_we && (mmio_offset == REG_GPIO);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
    assign lane_we[gi] = ram_we & bus.byte_enable[gi];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) ram_mem[ram_addr][8*i +: 8] <= bus.data_write[8*i +: 8];
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (mmio_we),
    .offset    (mmio_offset),
    .wdata     (bus.data_write),
    .be        (bus.byte_enable),
    .rdata     (timer_rdata),
    .timer_irq (timer_irq)
  );

  assign gpio_next = gpio_wr ? merge_lanes(gpio_reg, bus.data_write, bus.byte_enable)
                             : gpio_reg;

  always_ff @(posedge clk) begin
    if (reset) gpio_reg <= '0;
    else       gpio_reg <= gpio_next;
  end

  // Read path samples the pre-edge state, so a read of the word being
  // stored returns the old contents.
  always_ff @(posedge clk) begin
    if (reset)         data_read_reg <= '0;
    else if (ram_hit)  data_read_reg <= ram_mem[ram_addr];
    else if (mmio_hit) data_read_reg <= (mmio_offset == REG_GPIO) ? gpio_reg : timer_rdata;
    else               data_read_reg <= '0;
  end

  assign bus.data_read = data_read_reg;
  assign gpio_out      = gpio_reg;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder (RAM_WORDS = 32 so a gap exists).
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_out;
  logic        timer_irq;
  int          n_checks = 0;
  int          n_fail   = 0;

  data_bus_responder_if bus_if ();

  data_bus_responder #(.RAM_WORDS(32), .MMIO_BASE(8'hF0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] d);
    bus_if.access_address = a;
    bus_if.write_enable   = we;
    bus_if.byte_enable    = be;
    bus_if.data_write     = d;
  endtask

  // Leaves the bench at the start of the first cycle out of reset (COUNT = 0).
  task automatic do_reset();
    reset = 1'b1;
    drive(8'hF0, 1'b0, 4'h0, 32'h0);
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8'hF0, 1'b0, 4'h0, 32'h0);
    repeat (3) cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h0 || gpio_out !== 32'h0 || timer_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: data_read=%h gpio=%h irq=%b, required 0/0/0",
               bus_if.data_read, gpio_out, timer_irq);
    end else $display("ok   reset_outputs: all zero");
    reset = 1'b0;
    cycle();                        // cycle 1 shows COUNT of cycle 0
    n_checks++;
    if (bus_if.data_read !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_count: data_read=%h, required 00000000", bus_if.data_read);
    end else $display("ok   reset_count: %h", bus_if.data_read);
    drive(8'hF4, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_compare: data_read=%h, required ffffffff", bus_if.data_read);
    end else $display("ok   reset_compare: %h", bus_if.data_read);
    drive(8'hF8, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status: data_read=%h, required 00000000", bus_if.data_read);
    end else $display("ok   reset_status: %h", bus_if.data_read);
  endtask

  task automatic test_ram();
    drive(8'h08, 1'b1, 4'hF, 32'h1122_3344);
    cycle();
    drive(8'h08, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL ram_full_store: data_read=%h, required 11223344", bus_if.data_read);
    end else $display("ok   ram_full_store: %h", bus_if.data_read);
    drive(8'h08, 1'b1, 4'b0101, 32'hAABB_CCDD);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL ram_read_during_write: data_read=%h, required 11223344", bus_if.data_read);
    end else $display("ok   ram_read_during_write: %h", bus_if.data_read);
    drive(8'h08, 1'b1, 4'b0000, 32'hFFFF_FFFF);   // be=0 store is a no-op
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL ram_lane_store: data_read=%h, required 11bb33dd", bus_if.data_read);
    end else $display("ok   ram_lane_store: %h", bus_if.data_read);
    drive(8'h08, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL ram_be_zero_noop: data_read=%h, required 11bb33dd", bus_if.data_read);
    end else $display("ok   ram_be_zero_noop: %h", bus_if.data_read);
  endtask

  task automatic test_gap();
    drive(8'h10, 1'b1, 4'hF, 32'h0BAD_BEEF);
    cycle();
    drive(8'h7C, 1'b1, 4'hF, 32'h5A5A_1234);   // last RAM word
    cycle();
    drive(8'h90, 1'b1, 4'hF, 32'hCAFE_F00D);   // gap store, ignored
    cycle();
    drive(8'h90, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h0) begin
      n_fail++;
      $display("FAIL gap_read: data_read=%h, required 00000000", bus_if.data_read);
    end else $display("ok   gap_read: %h", bus_if.data_read);
    drive(8'h10, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h0BAD_BEEF) begin
      n_fail++;
      $display("FAIL gap_no_alias: data_read=%h, required 0badbeef", bus_if.data_read);
    end else $display("ok   gap_no_alias: %h", bus_if.data_read);
    drive(8'h7C, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h5A5A_1234) begin
      n_fail++;
      $display("FAIL ram_last_word: data_read=%h, required 5a5a1234", bus_if.data_read);
    end else $display("ok   ram_last_word: %h", bus_if.data_read);
  endtask

  task automatic test_timer_irq();
    do_reset();
    drive(8'hF4, 1'b1, 4'hF, 32'd20);          // cycle 0: COMPARE = 20
    cycle();
    drive(8'hF8, 1'b0, 4'h0, 32'h0);           // cycle 1 onward: read STATUS
    repeat (20) cycle();                       // cycle 21: STATUS seen in cycle 20
    n_checks++;
    if (bus_if.data_read !== 32'h0 || timer_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_before_match: status=%h irq=%b, required 00000000/0",
               bus_if.data_read, timer_irq);
    end else $display("ok   timer_before_match: status=%h", bus_if.data_read);
    cycle();                                   // cycle 22: STATUS of cycle 21
    n_checks++;
    if (bus_if.data_read !== 32'h1 || timer_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_match_no_irq: status=%h irq=%b, required 00000001/0",
               bus_if.data_read, timer_irq);
    end else $display("ok   timer_match_no_irq: status=%h", bus_if.data_read);
    drive(8'hF8, 1'b1, 4'b0001, 32'h2);        // irq_en=1, no clear
    cycle();
    n_checks++;
    if (timer_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_irq_enable: timer_irq=%b, required 1", timer_irq);
    end else $display("ok   timer_irq_enable: timer_irq=%b", timer_irq);
    drive(8'hF8, 1'b1, 4'b0001, 32'h3);        // clear match, keep irq_en
    cycle();
    n_checks++;
    if (timer_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_w1c: timer_irq=%b, required 0", timer_irq);
    end else $display("ok   timer_w1c: timer_irq=%b", timer_irq);
    drive(8'hF8, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h2) begin
      n_fail++;
      $display("FAIL timer_status_after_clear: status=%h, required 00000002", bus_if.data_read);
    end else $display("ok   timer_status_after_clear: %h", bus_if.data_read);
  endtask

  task automatic test_w1c_race();
    do_reset();
    drive(8'hF4, 1'b1, 4'hF, 32'd0);           // cycle 0: COMPARE = current COUNT
    cycle();
    drive(8'hF8, 1'b0, 4'h0, 32'h0);
    repeat (2) cycle();                        // cycle 3: STATUS of cycle 2
    n_checks++;
    if (bus_if.data_read !== 32'h0) begin
      n_fail++;
      $display("FAIL no_retro_match: status=%h, required 00000000", bus_if.data_read);
    end else $display("ok   no_retro_match: %h", bus_if.data_read);
    drive(8'hF4, 1'b1, 4'hF, 32'd8);           // cycle 3: COMPARE = 8
    cycle();
    drive(8'hF8, 1'b0, 4'h0, 32'h0);
    repeat (4) cycle();                        // cycle 8: COUNT == COMPARE
    drive(8'hF8, 1'b1, 4'b0001, 32'h1);        // W1C on the match cycle
    cycle();
    drive(8'hF8, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h1) begin
      n_fail++;
      $display("FAIL w1c_set_wins: status=%h, required 00000001", bus_if.data_read);
    end else $display("ok   w1c_set_wins: %h", bus_if.data_read);
  endtask

  task automatic test_gpio_count();
    do_reset();
    drive(8'hF0, 1'b0, 4'h0, 32'h0);           // cycle 0
    cycle();
    repeat (5) cycle();                        // cycle 6: COUNT of cycle 5
    n_checks++;
    if (bus_if.data_read !== 32'd5) begin
      n_fail++;
      $display("FAIL count_advance: data_read=%0d, required 5", bus_if.data_read);
    end else $display("ok   count_advance: %0d", bus_if.data_read);
    drive(8'hF0, 1'b1, 4'hF, 32'h1234_5678);   // cycle 6: store to COUNT
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'd6) begin
      n_fail++;
      $display("FAIL count_during_store: data_read=%0d, required 6", bus_if.data_read);
    end else $display("ok   count_during_store: %0d", bus_if.data_read);
    drive(8'hF0, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'd7) begin
      n_fail++;
      $display("FAIL count_read_only: data_read=%0d, required 7", bus_if.data_read);
    end else $display("ok   count_read_only: %0d", bus_if.data_read);
    drive(8'hFC, 1'b1, 4'b1100, 32'hDEAD_BEEF);
    cycle();
    n_checks++;
    if (gpio_out !== 32'hDEAD_0000) begin
      n_fail++;
      $display("FAIL gpio_lane_store: gpio_out=%h, required dead0000", gpio_out);
    end else $display("ok   gpio_lane_store: %h", gpio_out);
    drive(8'hFC, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'hDEAD_0000) begin
      n_fail++;
      $display("FAIL gpio_readback: data_read=%h, required dead0000", bus_if.data_read);
    end else $display("ok   gpio_readback: %h", bus_if.data_read);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(8'hFC, 1'b1, 4'hF, 32'h1234_5678);
    cycle();
    n_checks++;
    if (gpio_out !== 32'h0 || bus_if.data_read !== 32'h0 || timer_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_store: gpio=%h data_read=%h irq=%b, required 0/0/0",
               gpio_out, bus_if.data_read, timer_irq);
    end else $display("ok   reset_mid_store: outputs zero");
    drive(8'h10, 1'b1, 4'hF, 32'h0);           // RAM store under reset
    cycle();
    reset = 1'b0;
    drive(8'h10, 1'b0, 4'h0, 32'h0);
    cycle();
    n_checks++;
    if (bus_if.data_read !== 32'h0BAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_blocks_ram: data_read=%h, required 0badbeef", bus_if.data_read);
    end else $display("ok   reset_blocks_ram: %h", bus_if.data_read);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gap();
    test_timer_irq();
    test_w1c_race();
    test_gpio_count();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
